btn_input_sync: RTL and testbench

Input-side conditioning block for the FPGA top, complementing the inverted active-low LED outputs with active-low push-button inputs. It synchronises raw board buttons into the system clock domain and debounces them. It produces clean active-high levels, single-cycle press/release pulses and sticky press-event flags that the CPU clears by handshake. It sits between the board pins and MU_CPU and runs on the divided system clock.

---
 rtl/btn_input_sync_pkg.sv | 21 ++
 rtl/btn_input_sync_if.sv | 24 ++
 rtl/btn_input_sync_debounce_bit.sv | 99 +++++++++
 rtl/btn_input_sync.sv | 47 ++++
 tb/tb_btn_input_sync.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/btn_input_sync_pkg.sv
// Shared definitions for the button conditioning block: debounce state
// encoding and the default debounce length for the clk_sys frequency.
package btn_input_sync_pkg;

  localparam int CLK_SYS_HZ         = 50_000_000;
  localparam int DEB_MS             = 1;
  localparam int DEB_CYCLES_DEFAULT = (CLK_SYS_HZ / 1000) * DEB_MS;

  // Bit 1 of the encoding is the debounced level.
  typedef enum logic [1:0] {
    REL   = 2'b00,
    CHK_P = 2'b01,
    HELD  = 2'b11,
    CHK_R = 2'b10
  } deb_state_t;

  function automatic logic level_of(input deb_state_t st);
    return (st == HELD) || (st == CHK_R);
  endfunction

endpackage

// File: rtl/btn_input_sync_if.sv
// Board/CPU-facing signal bundle of the button conditioning block.
interface btn_input_sync_if #(
  parameter int N_BTN = 2
);

  logic [N_BTN-1:0] btn_n;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] evt_pending;
  logic [N_BTN-1:0] evt_clr;
  logic             evt_any;

  modport master (
    output btn_n, evt_clr,
    input  btn_level, btn_press, btn_release, evt_pending, evt_any
  );

  modport slave (
    input  btn_n, evt_clr,
    output btn_level, btn_press, btn_release, evt_pending, evt_any
  );

endinterface

// File: rtl/btn_input_sync_debounce_bit.sv
// One button: two-flop synchroniser, debounce FSM with stability counter,
// registered level and single-cycle press/release pulses.
module btn_input_sync_debounce_bit
  import btn_input_sync_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic rel_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync_p0, sync_p1;
  logic             s;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt;

  // Synchroniser resets to the released (high) pin level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
    end
  end

  assign s = ~sync_p1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      REL: if (s) begin
        state_nxt = CHK_P;
        cnt_nxt   = CNT_ONE;
      end
      CHK_P: begin
        if (!s) begin
          state_nxt = REL;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HELD: if (!s) begin
        state_nxt = CHK_R;
        cnt_nxt   = CNT_ONE;
      end
      CHK_R: begin
        if (s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = REL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = REL;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level_nxt = level_of(state_nxt);

  // Pulses derive from the next level so they coincide with the level edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= REL;
      cnt       <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
      rel_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      level     <= level_nxt;
      press     <= level_nxt & ~level;
      rel_pulse <= ~level_nxt & level;
    end
  end

endmodule

// File: rtl/btn_input_sync.sv
// Button input conditioning: per-button debounce plus sticky press-event
// flags cleared by CPU write-1-to-clear.
module btn_input_sync
  import btn_input_sync_pkg::*;
#(
  parameter int N_BTN      = 2,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  btn_input_sync_if.slave bus
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [N_BTN-1:0] level, press, rel_pulse, pending;

  for (genvar i = 0; i < N_BTN; i++) begin : g_deb
    btn_input_sync_debounce_bit #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .btn_n     (bus.btn_n[i]),
      .level     (level[i]),
      .press     (press[i]),
      .rel_pulse (rel_pulse[i])
    );
  end

  // A press arriving with a clear keeps the flag set so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~bus.evt_clr) | press;
    end
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel_pulse;
  assign bus.evt_pending = pending;
  assign bus.evt_any     = |pending;

endmodule

// File: tb/tb_btn_input_sync.sv
// Self-checking bench for btn_input_sync: directed scenarios plus random
// button activity, compared every cycle against a behavioural model.
module tb_btn_input_sync;

  localparam int N = 2;
  localparam int D = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  btn_input_sync_if #(.N_BTN(N)) bus ();

  btn_input_sync #(
    .N_BTN      (N),
    .DEB_CYCLES (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: pin samples pass through two sample delays; the accepted level
  // flips once the sample has disagreed with it for D+1 consecutive cycles.
  logic [N-1:0] m_d1, m_d2, m_lvl, m_press, m_rel, m_pend;
  int           m_run [N];

  task automatic model_reset();
    m_d1    = '1;
    m_d2    = '1;
    m_lvl   = '0;
    m_press = '0;
    m_rel   = '0;
    m_pend  = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] smp;
    smp    = ~m_d2;
    m_pend = (m_pend & ~bus.evt_clr) | m_press;
    m_d2   = m_d1;
    m_d1   = bus.btn_n;
    for (int i = 0; i < N; i++) begin
      m_press[i] = 1'b0;
      m_rel[i]   = 1'b0;
      if (smp[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_lvl[i]   = smp[i];
          m_run[i]   = 0;
          m_press[i] = smp[i];
          m_rel[i]   = ~smp[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_level"},   bus.btn_level,   m_lvl);
    chk({tag, "_press"},   bus.btn_press,   m_press);
    chk({tag, "_release"}, bus.btn_release, m_rel);
    chk({tag, "_pending"}, bus.evt_pending, m_pend);
    chk({tag, "_any"},     bus.evt_any,     |m_pend);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    int press_at, rel_at, p0_at, p1_at, npress;
    logic any_at_p1;
    checks = 0;
    errors = 0;
    rst         = 1'b1;
    bus.btn_n   = 2'b11;
    bus.evt_clr = 2'b00;
    model_reset();

    // Reset hold, then release reset with button 0 already pressed.
    repeat (3) step("rst");
    #2 rst = 1'b0;
    bus.btn_n = 2'b10;
    for (int j = 0; j <= 7; j++) begin
      step("t1");
      if (j == 5) chk("t1_level_before", bus.btn_level, 2'b00);
      if (j == 6) chk("t1_press_edge6", bus.btn_press, 2'b01);
      if (j == 6) chk("t1_level_edge6", bus.btn_level, 2'b01);
      if (j == 7) chk("t1_press_width", bus.btn_press, 2'b00);
    end
    bus.btn_n = 2'b11;
    repeat (8) step("t1r");
    bus.evt_clr = 2'b01;
    step("t1c");
    bus.evt_clr = 2'b00;
    chk("t1_cleared", bus.evt_pending, 2'b00);

    // Bounce shorter than the debounce window.
    for (int j = 0; j < 16; j++) begin
      bus.btn_n[0] = !((j < 3) || (j >= 4 && j < 7));
      step("t2");
      chk("t2_no_press", bus.btn_press, 2'b00);
    end
    chk("t2_level", bus.btn_level, 2'b00);
    chk("t2_pending", bus.evt_pending, 2'b00);

    // Full press and release.
    press_at = -1;
    rel_at   = -1;
    for (int j = 0; j < 20; j++) begin
      bus.btn_n[0] = (j >= 10);
      step("t3");
      if (bus.btn_press[0])   press_at = j;
      if (bus.btn_release[0]) rel_at   = j;
    end
    chk("t3_press_at", press_at, 6);
    chk("t3_release_at", rel_at, 16);
    chk("t3_pending_kept", bus.evt_pending, 2'b01);
    chk("t3_any_kept", bus.evt_any, 1'b1);

    // Handshake: selective clear, then clear colliding with a new press.
    bus.btn_n = 2'b01;
    repeat (8) step("t4p");
    bus.btn_n = 2'b11;
    repeat (8) step("t4r");
    chk("t4_both", bus.evt_pending, 2'b11);
    bus.evt_clr = 2'b01;
    step("t4c");
    bus.evt_clr = 2'b00;
    chk("t4_clr0", bus.evt_pending, 2'b10);
    bus.btn_n = 2'b01;
    for (int j = 0; j <= 8; j++) begin
      step("t4s");
      if (j == 6) begin
        chk("t4_press1", bus.btn_press, 2'b10);
        bus.evt_clr = 2'b10;
      end
      if (j == 7) begin
        chk("t4_set_wins", bus.evt_pending, 2'b10);
        bus.evt_clr = 2'b00;
      end
    end
    bus.btn_n = 2'b11;
    repeat (8) step("t4x");

    // Async reset between edges while counting a press.
    bus.btn_n = 2'b10;
    for (int j = 0; j <= 3; j++) step("t5a");
    #3 rst = 1'b1;
    model_reset();
    #1 compare_all("t5_async");
    chk("t5_pending_zero", bus.evt_pending, 2'b00);
    bus.btn_n = 2'b11;
    repeat (2) step("t5h");
    #3 rst = 1'b0;
    npress = 0;
    for (int j = 0; j < 10; j++) begin
      step("t5b");
      if (bus.btn_press != 2'b00) npress++;
    end
    chk("t5_no_press", npress, 0);

    // Reset while held: press is reported again after reset release.
    bus.btn_n = 2'b10;
    repeat (8) step("t5c");
    #3 rst = 1'b1;
    model_reset();
    #1 compare_all("t5_async_held");
    step("t5d");
    #3 rst = 1'b0;
    repeat (10) step("t5e");
    bus.btn_n = 2'b11;
    repeat (8) step("t5f");
    bus.evt_clr = 2'b11;
    step("t5g");
    bus.evt_clr = 2'b00;

    // Independence: presses one cycle apart.
    p0_at = -1;
    p1_at = -1;
    any_at_p1 = 1'b0;
    for (int j = 0; j < 12; j++) begin
      bus.btn_n = (j == 0) ? 2'b10 : 2'b00;
      step("t6");
      if (bus.btn_press[0]) p0_at = j;
      if (bus.btn_press[1]) begin
        p1_at = j;
        any_at_p1 = bus.evt_any;
      end
    end
    chk("t6_p0_at", p0_at, 6);
    chk("t6_p1_at", p1_at, 7);
    chk("t6_any_first", any_at_p1, 1'b1);
    bus.btn_n = 2'b11;
    repeat (8) step("t6r");

    // Random activity with runs of varying length and random clears.
    for (int j = 0; j < 400; j++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) bus.btn_n[i] = ~bus.btn_n[i];
        bus.evt_clr[i] = ($urandom_range(0, 7) == 0);
      end
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
